ps2_rx: RTL and testbench

PS/2 keyboard receiver feeding the typing front end. It synchronises and deglitches the raw `ps2clk`/`ps2data` lines and deframes 11-bit device-to-host frames with parity/stop checking and a mid-frame timeout. It folds the `E0` (extended) and `F0` (break) prefixes into flags, and presents a held scancode with a one-cycle valid strobe to the scancode-to-ASCII stage.

---
 rtl/ps2_rx_if.sv | 11 +
 rtl/ps2_rx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Decoded-scancode bus from the PS/2 receiver to the scancode-to-ASCII stage.
interface ps2_rx_if;
  logic [7:0] scancode;
  logic       valid;
  logic       is_break;
  logic       is_ext;
  logic       frame_err;

  modport master (output scancode, output valid, output is_break, output is_ext, output frame_err);
  modport slave  (input  scancode, input  valid, input  is_break, input  is_ext, input  frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line synchronisation, clock deglitching,
// 11-bit frame deframing with odd parity / stop / timeout checks, and
// folding of E0 (extended) and F0 (break) prefixes into flags.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ps2clk,
  input  logic     ps2data,
  ps2_rx_if.master rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // A completed frame is good when the stop bit is high and data plus parity
  // carry an odd number of ones.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic stop);
    return stop && ((^d) ^ p);
  endfunction

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic          clk_p0, clk_p1;
  logic          dat_p0, dat_p1;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic          fall;
  state_t        state, state_nx;
  logic [TW-1:0] tcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic          done, err, tmo;
  logic          ext_pend, brk_pend;
  logic [7:0]    scancode;
  logic          valid, is_break, is_ext, frame_err;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two-flop synchronisers for the raw lines; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2data;
      dat_p1 <= dat_p0;
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN equal samples; fall marks 1->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_p1 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        fclk <= clk_p1;
        fcnt <= '0;
        fall <= fclk & ~clk_p1;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and frame completion events; a timeout overrides any coincident fall.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    err      = 1'b0;
    tmo      = 1'b0;
    if (state != IDLE && tcnt == TMAX) begin
      state_nx = IDLE;
      err      = 1'b1;
      tmo      = 1'b1;
    end else begin
      case (state)
        IDLE:   if (fall && !dat_p1) state_nx = DATA;
        DATA:   if (fall && bitcnt == 3'd7) state_nx = PARITY;
        PARITY: if (fall) state_nx = STOP;
        STOP: begin
          if (fall) begin
            state_nx = IDLE;
            if (frame_ok(shreg, par, dat_p1)) done = 1'b1;
            else                              err  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Inter-bit timeout counter, bit counter, shift register and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
    end else begin
      if (state_nx == IDLE || fall) tcnt <= '0;
      else                          tcnt <= tcnt + TW'(1);
      if (!tmo && fall) begin
        case (state)
          IDLE: begin
            bitcnt <= '0;
            shreg  <= '0;
          end
          DATA: begin
            bitcnt <= bitcnt + 3'd1;
            shreg  <= {dat_p1, shreg[7:1]};
          end
          PARITY:  par <= dat_p1;
          default: ;
        endcase
      end
    end
  end

  // Prefix folding and registered outputs; strobes last a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scancode  <= 8'h00;
      valid     <= 1'b0;
      is_break  <= 1'b0;
      is_ext    <= 1'b0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= err;
      if (done) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          scancode <= shreg;
          is_ext   <= ext_pend;
          is_break <= brk_pend;
          valid    <= 1'b1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end else if (err && !tmo) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign rx.scancode  = scancode;
  assign rx.valid     = valid;
  assign rx.is_break  = is_break;
  assign rx.is_ext    = is_ext;
  assign rx.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames are driven bit by bit on the raw lines,
// the expected decode events are queued before each frame and checked by a
// monitor as the receiver reports them.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    int         lat;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;

  ps2_rx_if rx ();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2clk  (ps2clk),
    .ps2data (ps2data),
    .rx      (rx)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_fall = 0;
  int  ev_cnt = 0;
  ev_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit err, input logic [7:0] code, input bit brk, input bit ext, input int lat);
    ev_t e;
    e.err = err; e.code = code; e.brk = brk; e.ext = ext; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ flip);
    send_bit(1'b1);
  endtask

  // Compare every reported event against the head of the expectation queue.
  always @(negedge clk) begin
    if (rx.valid || rx.frame_err) begin
      ev_t e;
      ev_cnt++;
      chk("excl", 32'(rx.valid & rx.frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("kind_err", 32'(rx.frame_err), 32'(e.err));
        if (!e.err) begin
          chk("scancode", 32'(rx.scancode), 32'(e.code));
          chk("is_break", 32'(rx.is_break), 32'(e.brk));
          chk("is_ext", 32'(rx.is_ext), 32'(e.ext));
        end
        if (e.lat >= 0) chk("latency", 32'(cyc - last_fall), 32'(e.lat));
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_scancode"}, 32'(rx.scancode), 32'd0);
    chk({tag, "_valid"}, 32'(rx.valid), 32'd0);
    chk({tag, "_is_break"}, 32'(rx.is_break), 32'd0);
    chk({tag, "_is_ext"}, 32'(rx.is_ext), 32'd0);
    chk({tag, "_frame_err"}, 32'(rx.frame_err), 32'd0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (5) @(negedge clk);
    chk_outs_zero("rst");
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk_outs_zero("post_rst");

    // plain 0x1C, with latency from the stop-bit raw edge
    push(1'b0, 8'h1C, 1'b0, 1'b0, FL + 3);
    send_frame(8'h1C, 1'b0);

    // break prefix, then an unprefixed key
    push(1'b0, 8'h1C, 1'b1, 1'b0, FL + 3);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    push(1'b0, 8'h1C, 1'b0, 1'b0, FL + 3);
    send_frame(8'h1C, 1'b0);

    // extended break with a repeated prefix
    push(1'b0, 8'h75, 1'b1, 1'b1, FL + 3);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);

    // parity error keeps scancode and drops the pending E0
    send_frame(8'hE0, 1'b0);
    push(1'b1, 8'h00, 1'b0, 1'b0, FL + 3);
    send_frame(8'h1C, 1'b1);
    chk("keep_scancode", 32'(rx.scancode), 32'h75);
    push(1'b0, 8'h1C, 1'b0, 1'b0, FL + 3);
    send_frame(8'h1C, 1'b0);

    // timeout after 4 data bits; a pending F0 survives it
    send_frame(8'hF0, 1'b0);
    push(1'b1, 8'h00, 1'b0, 1'b0, FL + 3 + TO);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2));
    repeat (TO + 40) @(negedge clk);
    chk("timeout_seen", 32'(sb.size()), 32'd0);
    push(1'b0, 8'h16, 1'b1, 1'b0, FL + 3);
    send_frame(8'h16, 1'b0);

    // short low glitches with data low must not start a frame
    n = ev_cnt;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      ps2data = 1'b0;
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    ps2data = 1'b1;
    repeat (TO + 50) @(negedge clk);
    chk("glitch_no_event", 32'(ev_cnt), 32'(n));

    // reset mid-frame clears outputs at once, then a fresh frame decodes
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outs_zero("mid_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (TO + 50) @(negedge clk);
    push(1'b0, 8'h45, 1'b0, 1'b0, FL + 3);
    send_frame(8'h45, 1'b0);

    repeat (50) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
